// File: rtl/apb_slave_regbank.sv
// APB3 responder: bank of DEPTH 32-bit read/write registers with programmable wait states.
// Out-of-range and misaligned accesses complete with Pslverr and leave the bank untouched.
module apb_slave_regbank #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned WAIT_W    = 4
) (
  input  logic              Pclk,
  input  logic              Preset,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [31:0]       Paddr,
  input  logic [31:0]       Pwdata,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [31:0]       Prdata,
  output logic              Pready,
  output logic              Pslverr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic              wr_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       rdata_q;
  logic [31:0]       regs [DEPTH];

  logic [31:0]       off;
  logic              dec_err;
  logic [IDX_W-1:0]  dec_idx;
  logic              setup;

  always_comb begin
    off     = Paddr - BASE_ADDR;
    dec_err = (Paddr < BASE_ADDR) || (off >= SPAN) || (Paddr[1:0] != 2'b00);
    dec_idx = off[IDX_W+1:2];
  end

  assign setup   = Psel & ~Penable;
  assign Pready  = (state == ACCESS) && (cnt == '0) && Psel && Penable;
  assign Pslverr = Pready & err_q;
  assign Prdata  = (Pready && !wr_q) ? rdata_q : 32'h0;

  // Read data is captured at SETUP; a write lands at the completion edge, which
  // always precedes the next SETUP edge, so back-to-back RAW needs no bypass.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      rdata_q <= 32'h0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 32'h0;
    end else if (setup) begin
      // A SETUP seen mid-access restarts the transfer with fresh captures.
      state   <= ACCESS;
      cnt     <= wait_cfg;
      wr_q    <= Pwrite;
      err_q   <= dec_err;
      idx_q   <= dec_idx;
      rdata_q <= dec_err ? 32'h0 : regs[dec_idx];
    end else if (state == ACCESS) begin
      if (!Psel) begin
        state <= IDLE;
      end else if (cnt != '0) begin
        cnt <= cnt - WAIT_W'(1);
      end else begin
        if (wr_q && !err_q) regs[idx_q] <= Pwdata;
        state <= IDLE;
      end
    end
  end

endmodule
